uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with a configurable bit period and data
// width. The line is synchronised, a falling edge starts a frame, each bit is
// sampled at mid-period, and the stop bit decides between a data pulse and a
// framing-error pulse.
module uart_rx #(
  parameter int BPS_MAX = 5208,
  parameter int BIT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam int CNT_W = (BPS_MAX > 1) ? $clog2(BPS_MAX) : 1;
  localparam int BIT_W = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(BPS_MAX / 2);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(BPS_MAX - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_rx_s1;
  logic               r_rx_s2;
  logic               r_rx_s3;
  logic [1:0]         r_sync_fill;
  logic [CNT_W-1:0]   r_bps_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_MAX-1:0] r_shift;
  logic               w_sync_ready;
  logic               w_start_edge;
  logic               w_sample;
  logic               w_bit_end;
  logic               w_stop_good;
  logic               w_stop_bad;

  // The synchroniser flops are preset high, so right after reset s3 still
  // holds the preset value while s2 already carries the real line. Edges are
  // only trusted once three real samples have passed through (r_sync_fill),
  // which stops a line held low across reset release from looking like a
  // start bit.
  assign w_sync_ready = (r_sync_fill == 2'd3);
  assign w_start_edge = w_sync_ready & ~r_rx_s2 & r_rx_s3;
  assign w_sample     = (r_bps_cnt == SAMPLE_PT);
  assign w_bit_end    = (r_bps_cnt == BIT_END);
  assign w_stop_good  = (r_state == STOP) & w_sample & r_rx_s2;
  assign w_stop_bad   = (r_state == STOP) & w_sample & ~r_rx_s2;
  assign rx_busy      = (r_state != IDLE);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_s3     <= 1'b1;
      r_sync_fill <= 2'd0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (!w_sync_ready) begin
        r_sync_fill <= r_sync_fill + 2'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; STOP returns to IDLE at its sample point so a
  // back-to-back start bit is not missed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_sample && r_rx_s2) begin
          w_state_next = IDLE;
        end else if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-period counter: parked at zero in IDLE, restarted at every bit end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bps_cnt <= '0;
    end else if ((r_state == IDLE) || (w_state_next == IDLE) || w_bit_end) begin
      r_bps_cnt <= '0;
    end else begin
      r_bps_cnt <= r_bps_cnt + CNT_W'(1);
    end
  end

  // Data-bit counter, live only while in DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
    end else if (r_state != DATA) begin
      r_bit_cnt <= '0;
    end else if (w_bit_end) begin
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_W'(1);
    end
  end

  // LSB-first shift register: each new bit enters at the top and moves down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else if ((r_state == DATA) && w_sample) begin
      r_shift <= {r_rx_s2, r_shift[BIT_MAX-1:1]};
    end
  end

  // Output word and one-cycle result pulses, decided by the stop-bit sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= w_stop_good;
      rx_err   <= w_stop_bad;
      if (w_stop_good) begin
        rx_data <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BPS_MAX = 16, BIT_MAX = 8. Sent good frames
// push their byte to an expected queue; a negedge monitor collects every
// rx_valid word, and the main sequence compares them in order.
module tb_uart_rx;

  localparam int BPS = 16;
  localparam int NB  = 8;

  logic          clk;
  logic          rst;
  logic          rx;
  logic [NB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          rx_busy;

  int checks = 0;
  int errors = 0;

  // Monitor-owned observations.
  logic [NB-1:0] got_q[$];
  int            valid_cnt     = 0;
  int            err_cnt       = 0;
  int            both_cnt      = 0;
  int            stable_viol   = 0;
  int            last_valid_cyc = 0;
  logic [NB-1:0] prev_data     = '0;
  int            cyc           = 0;

  // Main-sequence bookkeeping.
  logic [NB-1:0] exp_q[$];
  int            rd_idx   = 0;
  int            fall_cyc = 0;
  int            v0;
  int            e0;
  int            lat;

  uart_rx #(
    .BPS_MAX(BPS),
    .BIT_MAX(NB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (rx_err) err_cnt <= err_cnt + 1;
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
    if (rst && !rx_valid && (rx_data !== prev_data)) stable_viol <= stable_viol + 1;
    prev_data <= rx_data;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BPS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (BPS - 1) @(negedge clk);
    for (int i = 0; i < NB; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic wait_valid(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while ((valid_cnt < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(valid_cnt >= n), 32'd1);
  endtask

  task automatic compare_next(input string tag);
    logic [NB-1:0] e;
    e = exp_q.pop_front();
    chk({tag, "_avail"}, 32'(got_q.size() > rd_idx), 32'd1);
    if (got_q.size() > rd_idx) begin
      chk(tag, 32'(got_q[rd_idx]), 32'(e));
      $display("frame %s: got %02h expected %02h", tag, got_q[rd_idx], e);
    end
    rd_idx++;
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b0;
    idle_cycles(3);
    chk("rst_data",  32'(rx_data),  32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_err",   32'(rx_err),   32'd0);
    chk("rst_busy",  32'(rx_busy),  32'd0);
    rst = 1'b1;
    idle_cycles(10);

    // Single good frame, with latency measurement.
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_valid("to_55", 1, 40);
    lat = last_valid_cyc - fall_cyc;
    $display("frame 55 latency %0d cycles", lat);
    chk("lat_55", 32'((lat >= 155) && (lat <= 157)), 32'd1);
    compare_next("f55");
    chk("err_55", 32'(err_cnt), 32'd0);
    idle_cycles(10);

    // Back-to-back frames with no idle gap.
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_valid("to_b2b", 3, 40);
    compare_next("fA3");
    compare_next("f00");
    chk("cnt_b2b", 32'(valid_cnt), 32'd3);
    idle_cycles(10);

    // Short glitch on the line: must be rejected in START.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    idle_cycles(4);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(8);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    $display("glitch: busy=%0b after 13 cycles", rx_busy);
    idle_cycles(200);
    chk("glitch_valid", 32'(valid_cnt), 32'(v0));
    chk("glitch_err",   32'(err_cnt),   32'(e0));

    // Framing error, then a good frame.
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(20);
    $display("frame 3C bad stop: err pulses %0d", err_cnt - e0);
    chk("ferr_err",   32'(err_cnt),   32'(e0 + 1));
    chk("ferr_valid", 32'(valid_cnt), 32'(v0));
    chk("ferr_data",  32'(rx_data),   32'h00);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_valid("to_81", v0 + 1, 40);
    compare_next("f81");
    idle_cycles(10);

    // Reset in the middle of data bit 4 of 0xFF.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    idle_cycles(BPS - 1);
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(4 * BPS + 8 - 1);
    chk("abort_busy_pre", 32'(rx_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(rx_busy), 32'd0);
    chk("abort_data", 32'(rx_data), 32'd0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(200);
    $display("abort FF: valid pulses %0d err pulses %0d", valid_cnt - v0, err_cnt - e0);
    chk("abort_valid", 32'(valid_cnt), 32'(v0));
    chk("abort_err",   32'(err_cnt),   32'(e0));
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_valid("to_12", v0 + 1, 40);
    compare_next("f12");
    idle_cycles(10);

    // Line held low across reset release.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rx  = 1'b0;
    rst = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(200);
    $display("low-at-release: busy=%0b valid pulses %0d", rx_busy, valid_cnt - v0);
    chk("lowrel_busy",  32'(rx_busy),   32'd0);
    chk("lowrel_valid", 32'(valid_cnt), 32'(v0));
    chk("lowrel_err",   32'(err_cnt),   32'(e0));
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_valid("to_5A", v0 + 1, 40);
    compare_next("f5A");
    idle_cycles(10);

    // Global properties over the whole run.
    chk("total_valid", 32'(valid_cnt),    32'd6);
    chk("total_err",   32'(err_cnt),      32'd1);
    chk("never_both",  32'(both_cnt),     32'd0);
    chk("data_stable", 32'(stable_viol),  32'd0);
    chk("sb_drained",  32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
